agc_param_ctrl: RTL and testbench
=================================

// Module: agc_param_ctrl
// PURPOSE
// - Consumes the key/encoder front-end outputs (value[2:0], irq[2:0], slow-clock domain) and converts them into AGC control parameters.
// - Owns the AGC target level, enable, mute and attack-mode registers.
// - Publishes each parameter change to the AGC core through a valid/ready handshake.
// - Sits between the key scanner and the AGC gain core. Everything runs on the system clock.
// PARAMETERS
// - TGT_W        8      width of agc_target
// - TGT_DEF      96     agc_target value at reset and on the "defaults" key
// - TGT_MIN      16     lower saturation bound for agc_target
// - TGT_MAX      240    upper saturation bound for agc_target
// - STEP_FINE    1      encoder step size in fine mode
// - STEP_COARSE  8      step size in coarse mode, also used by keys 1/2
// PORTS
// - clk          in   1      system clock
// - rst_n        in   1      asynchronous active-low reset
// - key_value    in   3      key code from the scanner, 1..7, 0 = none
// - key_irq      in   3      [0] key press, [1] encoder right, [2] encoder left; levels, asynchronous to clk
// - agc_target   out  TGT_W  target output level
// - agc_enable   out  1      AGC loop enable
// - agc_mute     out  1      output mute
// - atk_mode     out  2      attack/release profile select
// - fine_mode    out  1      1 = encoder uses STEP_FINE, 0 = encoder uses STEP_COARSE
// - param_valid  out  1      parameter set changed; held high until accepted
// - param_ready  in   1      AGC core accepts the parameter set
// BEHAVIOUR
// - Reset (async, rst_n=0) forces:
//   - agc_target=TGT_DEF, agc_enable=1, agc_mute=0, atk_mode=0, fine_mode=1, param_valid=0
//   - FSM=IDLE, all pending flags and synchronisers cleared
//   - Reset asserted mid-handshake drops param_valid immediately; no publish occurs.
// - Input synchronisation: key_irq and key_value each pass through 2 FF stages, then a third FF for edge detection.
// - Events are rising edges of synced irq bits. key_value is captured with the irq[0] edge, 3 clk after the pin edge.
// - Pending flags: pend_key (with captured code), pend_r, pend_l.
//   - Each flag is set on its edge and cleared when serviced.
//   - A second edge of the same kind while its flag is set is dropped.
//   - pend_r and pend_l both set in the same cycle: both are cleared (net zero).
// - FSM IDLE -> APPLY -> PUBLISH -> IDLE:
//   - IDLE: if any flag is set, take the highest priority (key > right > left) and go to APPLY.
//   - APPLY: one cycle; update registers per the table below.
//     - If no register value actually changed, go to IDLE without asserting param_valid.
//     - Otherwise go to PUBLISH.
//   - PUBLISH: param_valid=1 with outputs stable. On param_valid&&param_ready, drop valid next cycle and go to IDLE.
//   - Events arriving during APPLY or PUBLISH only set pending flags.
// - Latency: pin edge to param_valid = 3 (sync) + 1 (IDLE) + 1 (APPLY) = 5 clk minimum.
// - Key table:
//   - 1: target += STEP_COARSE
//   - 2: target -= STEP_COARSE
//   - 3: toggle agc_enable
//   - 4: atk_mode += 1, wrapping 3 -> 0
//   - 5: toggle agc_mute
//   - 6: restore all reset values except fine_mode
//   - 7: toggle fine_mode
//   - 0: ignored, flag cleared, no publish
// - Encoder: right +step, left -step, where step = fine_mode ? STEP_FINE : STEP_COARSE.
// - Arithmetic: computed at TGT_W+1 bits, then saturated to [TGT_MIN, TGT_MAX]; no wrap-around.
//   - Already at a bound: the value is unchanged and no publish occurs.
// - agc_target and the other outputs change only in APPLY, never while param_valid=1.
// TESTING
// - Reset, then key_irq[0] rises with key_value=1, param_ready=1 -> agc_target 96->104; one param_valid pulse at clk 5.
// - fine_mode=1, agc_target=239, three right edges -> 240 after the first; the second and third produce no param_valid.
// - param_ready=0 for 20 clk after key 3 -> param_valid and agc_enable=0 held stable; release -> valid drops next clk.
// - Left and right edges in the same clk -> target unchanged, no publish. Key 4 pressed 5x -> atk_mode 1,2,3,0,1.
// - Key 0 event -> nothing published. Key 6 with target=40, mute=1 -> 96, mute=0, one publish.
// - rst_n low while param_valid=1 -> valid=0 and all outputs at reset values at once; pending edges lost.

Source files
------------

// File: rtl/agc_param_ctrl.sv
// agc_param_ctrl: turns synchronised key/encoder events into AGC parameters published over valid/ready
module agc_param_ctrl #(
  parameter int TGT_W       = 8,
  parameter int TGT_DEF     = 96,
  parameter int TGT_MIN     = 16,
  parameter int TGT_MAX     = 240,
  parameter int STEP_FINE   = 1,
  parameter int STEP_COARSE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       key_value,
  input  logic [2:0]       key_irq,
  output logic [TGT_W-1:0] agc_target,
  output logic             agc_enable,
  output logic             agc_mute,
  output logic [1:0]       atk_mode,
  output logic             fine_mode,
  output logic             param_valid,
  input  logic             param_ready
);
  typedef enum logic [1:0] {IDLE, APPLY, PUBLISH} state_t;
  typedef enum logic [1:0] {EV_KEY, EV_R, EV_L} ev_t;
  localparam logic [TGT_W-1:0] T_DEF = TGT_W'(TGT_DEF);
  localparam logic [TGT_W:0]   T_MIN = (TGT_W+1)'(TGT_MIN);
  localparam logic [TGT_W:0]   T_MAX = (TGT_W+1)'(TGT_MAX);
  localparam logic [TGT_W:0]   S_FINE = (TGT_W+1)'(STEP_FINE);
  localparam logic [TGT_W:0]   S_COARSE = (TGT_W+1)'(STEP_COARSE);
  state_t state_q, state_d;
  ev_t sel_q, sel_d;
  logic [2:0] irq_s1_q, irq_s2_q, irq_s3_q, kv_s1_q, kv_s2_q, rise;
  logic pend_key_q, pend_key_d, pend_r_q, pend_r_d, pend_l_q, pend_l_d, r_n, l_n;
  logic svc_key, svc_r;
  logic [2:0] code_q, code_d, act_q, act_d;
  logic [TGT_W-1:0] tgt_q, tgt_d, up_sat, dn_sat;
  logic [TGT_W:0] amt, sum, dif;
  logic en_q, en_d, mute_q, mute_d, fine_q, fine_d, is_key, inc, dec, changed;
  logic [1:0] atk_q, atk_d;
  assign rise = irq_s2_q & ~irq_s3_q;
  // Edges arriving while the same flag is still pending are dropped; opposing encoder steps cancel.
  always_comb begin
    svc_key = state_q == IDLE && pend_key_q;
    svc_r = state_q == IDLE && !pend_key_q && pend_r_q;
    pend_key_d = (pend_key_q & ~svc_key) | (rise[0] & ~pend_key_q);
    code_d = (rise[0] && !pend_key_q) ? kv_s2_q : code_q;
    r_n = (pend_r_q & ~svc_r) | (rise[1] & ~pend_r_q);
    l_n = (pend_l_q & ~(state_q == IDLE && !pend_key_q && !pend_r_q)) | (rise[2] & ~pend_l_q);
    pend_r_d = r_n & ~l_n;
    pend_l_d = l_n & ~r_n;
    sel_d = state_q != IDLE ? sel_q : pend_key_q ? EV_KEY : pend_r_q ? EV_R : EV_L;
    act_d = svc_key ? code_q : act_q;
  end
  // Saturating arithmetic one bit wider than the target so neither direction can wrap.
  always_comb begin
    is_key = sel_q == EV_KEY;
    amt = is_key ? S_COARSE : fine_q ? S_FINE : S_COARSE;
    sum = {1'b0, tgt_q} + amt;
    dif = {1'b0, tgt_q} - amt;
    up_sat = sum > T_MAX ? T_MAX[TGT_W-1:0] : sum[TGT_W-1:0];
    dn_sat = (dif[TGT_W] || dif < T_MIN) ? T_MIN[TGT_W-1:0] : dif[TGT_W-1:0];
    inc = sel_q == EV_R || (is_key && act_q == 3'd1);
    dec = sel_q == EV_L || (is_key && act_q == 3'd2);
    tgt_d = (is_key && act_q == 3'd6) ? T_DEF : inc ? up_sat : dec ? dn_sat : tgt_q;
    en_d = (is_key && act_q == 3'd6) ? 1'b1 : (is_key && act_q == 3'd3) ? ~en_q : en_q;
    mute_d = (is_key && act_q == 3'd6) ? 1'b0 : (is_key && act_q == 3'd5) ? ~mute_q : mute_q;
    atk_d = (is_key && act_q == 3'd6) ? 2'd0 : (is_key && act_q == 3'd4) ? atk_q + 2'd1 : atk_q;
    fine_d = (is_key && act_q == 3'd7) ? ~fine_q : fine_q;
    changed = {tgt_d, en_d, mute_d, atk_d, fine_d} != {tgt_q, en_q, mute_q, atk_q, fine_q};
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (pend_key_q || pend_r_q || pend_l_q) ? APPLY : IDLE;
      APPLY:   state_d = changed ? PUBLISH : IDLE;
      PUBLISH: state_d = param_ready ? IDLE : PUBLISH;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q <= EV_KEY;
      {irq_s1_q, irq_s2_q, irq_s3_q, kv_s1_q, kv_s2_q} <= '0;
      {pend_key_q, pend_r_q, pend_l_q} <= '0;
      code_q <= '0;
      act_q <= '0;
      tgt_q <= T_DEF;
      en_q <= 1'b1;
      mute_q <= 1'b0;
      atk_q <= '0;
      fine_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      {irq_s1_q, irq_s2_q, irq_s3_q} <= {key_irq, irq_s1_q, irq_s2_q};
      {kv_s1_q, kv_s2_q} <= {key_value, kv_s1_q};
      {pend_key_q, pend_r_q, pend_l_q} <= {pend_key_d, pend_r_d, pend_l_d};
      code_q <= code_d;
      act_q <= act_d;
      if (state_q == APPLY) begin
        tgt_q <= tgt_d;
        en_q <= en_d;
        mute_q <= mute_d;
        atk_q <= atk_d;
        fine_q <= fine_d;
      end
    end
  end
  assign agc_target = tgt_q;
  assign agc_enable = en_q;
  assign agc_mute = mute_q;
  assign atk_mode = atk_q;
  assign fine_mode = fine_q;
  assign param_valid = state_q == PUBLISH;
endmodule

// File: tb/tb_agc_param_ctrl.sv
// tb_agc_param_ctrl: directed scenario tasks with hand-computed expectations for agc_param_ctrl
module tb_agc_param_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, param_ready = 1'b1;
  logic [2:0] key_value = '0, key_irq = '0;
  logic [7:0] agc_target;
  logic agc_enable, agc_mute, fine_mode, param_valid;
  logic [1:0] atk_mode;
  int tests = 0, errors = 0, pubs = 0;
  agc_param_ctrl dut (
    .clk(clk), .rst_n(rst_n), .key_value(key_value), .key_irq(key_irq),
    .agc_target(agc_target), .agc_enable(agc_enable), .agc_mute(agc_mute),
    .atk_mode(atk_mode), .fine_mode(fine_mode), .param_valid(param_valid),
    .param_ready(param_ready)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (param_valid && param_ready) pubs++;
  // Raise the given irq bit(s) with a key code, drop them later and let the FSM settle.
  task automatic ev(input logic [2:0] bits, input logic [2:0] k);
    @(negedge clk);
    key_value = k;
    key_irq = bits;
    repeat (4) @(negedge clk);
    key_irq = '0;
    repeat (8) @(negedge clk);
  endtask
  task automatic chk_tgt(input string name, input int exp);
    tests++;
    if (agc_target !== 8'(exp)) begin
      errors++;
      $display("FAIL %s: agc_target=%0d expected %0d", name, agc_target, exp);
    end
  endtask
  task automatic chk_pubs(input string name, input int exp);
    tests++;
    if (pubs !== exp) begin
      errors++;
      $display("FAIL %s: publishes=%0d expected %0d", name, pubs, exp);
    end
  endtask
  task automatic test_reset;
    tests++;
    if ({agc_target, agc_enable, agc_mute, atk_mode, fine_mode, param_valid} !== {8'd96, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset: tgt=%0d en=%b mute=%b atk=%0d fine=%b valid=%b expected 96 1 0 0 1 0",
               agc_target, agc_enable, agc_mute, atk_mode, fine_mode, param_valid);
    end
  endtask
  task automatic test_latency;
    int p0 = pubs;
    @(negedge clk);
    key_value = 3'd1;
    key_irq = 3'b001;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      #1;
      tests++;
      if (param_valid !== (c == 5)) begin
        errors++;
        $display("FAIL latency clk%0d: param_valid=%b expected %b", c, param_valid, c == 5);
      end
    end
    key_irq = '0;
    repeat (8) @(negedge clk);
    chk_tgt("latency_target", 104);
    chk_pubs("latency_pubs", p0 + 1);
  endtask
  task automatic test_saturation;
    int p0;
    repeat (17) ev(3'b001, 3'd1);
    chk_tgt("sat_up_key", 240);
    ev(3'b100, 3'd0);
    chk_tgt("fine_left", 239);
    p0 = pubs;
    ev(3'b010, 3'd0);
    chk_tgt("fine_right", 240);
    chk_pubs("right_pub", p0 + 1);
    ev(3'b010, 3'd0);
    ev(3'b010, 3'd0);
    chk_tgt("right_at_max", 240);
    chk_pubs("no_pub_at_max", p0 + 1);
    repeat (28) ev(3'b001, 3'd2);
    chk_tgt("sat_down_key", 16);
    p0 = pubs;
    ev(3'b001, 3'd2);
    chk_tgt("key2_at_min", 16);
    chk_pubs("no_pub_at_min", p0);
  endtask
  task automatic test_both_encoder;
    int p0 = pubs;
    ev(3'b110, 3'd0);
    chk_tgt("both_target", 16);
    chk_pubs("both_no_pub", p0);
  endtask
  task automatic test_backpressure;
    int p0 = pubs;
    param_ready = 1'b0;
    ev(3'b001, 3'd3);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      tests++;
      if (param_valid !== 1'b1 || agc_enable !== 1'b0 || agc_target !== 8'd16) begin
        errors++;
        $display("FAIL hold clk%0d: valid=%b en=%b tgt=%0d expected 1 0 16", c, param_valid, agc_enable, agc_target);
      end
    end
    @(negedge clk);
    param_ready = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (param_valid !== 1'b0) begin
      errors++;
      $display("FAIL release: param_valid=%b expected 0", param_valid);
    end
    chk_pubs("backpressure_pubs", p0 + 1);
  endtask
  task automatic test_atk;
    logic [1:0] exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 5; i++) begin
      ev(3'b001, 3'd4);
      tests++;
      if (atk_mode !== exp[i]) begin
        errors++;
        $display("FAIL atk%0d: atk_mode=%0d expected %0d", i, atk_mode, exp[i]);
      end
    end
  endtask
  task automatic test_key0;
    int p0 = pubs;
    ev(3'b001, 3'd0);
    chk_pubs("key0_no_pub", p0);
    chk_tgt("key0_target", 16);
  endtask
  task automatic test_defaults;
    int p0;
    repeat (3) ev(3'b001, 3'd1);
    chk_tgt("pre_defaults", 40);
    ev(3'b001, 3'd5);
    ev(3'b001, 3'd7);
    tests++;
    if (agc_mute !== 1'b1 || fine_mode !== 1'b0) begin
      errors++;
      $display("FAIL mute_fine: mute=%b fine=%b expected 1 0", agc_mute, fine_mode);
    end
    ev(3'b010, 3'd0);
    chk_tgt("coarse_right", 48);
    p0 = pubs;
    ev(3'b001, 3'd6);
    chk_tgt("defaults_target", 96);
    tests++;
    if (agc_mute !== 1'b0 || agc_enable !== 1'b1 || atk_mode !== 2'd0 || fine_mode !== 1'b0) begin
      errors++;
      $display("FAIL defaults: mute=%b en=%b atk=%0d fine=%b expected 0 1 0 0", agc_mute, agc_enable, atk_mode, fine_mode);
    end
    chk_pubs("defaults_pub", p0 + 1);
  endtask
  task automatic test_reset_mid;
    int p0 = pubs;
    param_ready = 1'b0;
    ev(3'b001, 3'd1);
    tests++;
    if (param_valid !== 1'b1 || agc_target !== 8'd104) begin
      errors++;
      $display("FAIL pre_reset: valid=%b tgt=%0d expected 1 104", param_valid, agc_target);
    end
    @(negedge clk);
    key_irq = 3'b010;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    key_irq = '0;
    #1;
    tests++;
    if ({agc_target, agc_enable, agc_mute, atk_mode, fine_mode, param_valid} !== {8'd96, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: tgt=%0d en=%b mute=%b atk=%0d fine=%b valid=%b expected 96 1 0 0 1 0",
               agc_target, agc_enable, agc_mute, atk_mode, fine_mode, param_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    param_ready = 1'b1;
    repeat (15) @(negedge clk);
    chk_pubs("reset_no_pub", p0);
    chk_tgt("reset_edges_lost", 96);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_latency;
    test_saturation;
    test_both_encoder;
    test_backpressure;
    test_atk;
    test_key0;
    test_defaults;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
